// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: schedules ALU and load results onto the register file's single write port
// ALU results queue in a small FIFO, a load waits in a one-entry hold register.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              busy,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic              hazard,
  output logic              WRITE,
  output logic [ADDR_W-1:0] INADDRESS,
  output logic [DATA_W-1:0] IN
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] fa [FIFO_DEPTH];
  logic [DATA_W-1:0] fd [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fv, fg;
  logic [PW-1:0] rp, wp;
  logic [CW-1:0] cnt;
  logic hv;
  logic [ADDR_W-1:0] ha;
  logic [DATA_W-1:0] hd;
  logic full, pend, pop, pop_fifo, pop_hold, push, load;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // fg marks FIFO entries accepted no later than the current hold entry
  always_comb begin
    full      = cnt == CW'(FIFO_DEPTH);
    pend      = hv || cnt != '0;
    pop       = !busy && pend;
    pop_fifo  = pop && cnt != '0 && (!hv || full || (fa[rp] == ha && fg[rp]));
    pop_hold  = pop && !pop_fifo;
    alu_ready = RESET && (!full || pop_fifo);
    mem_ready = RESET && (!hv || pop_hold);
    push      = alu_valid && alu_ready;
    load      = mem_valid && mem_ready;
    state_nx  = !pend ? IDLE : (busy ? STALL : ISSUE);
  end

  always_comb begin
    hazard = (WRITE && (INADDRESS == rd1_addr || INADDRESS == rd2_addr)) ||
             (hv && (ha == rd1_addr || ha == rd2_addr));
    for (int i = 0; i < FIFO_DEPTH; i++)
      hazard = hazard || (fv[i] && (fa[i] == rd1_addr || fa[i] == rd2_addr));
  end

  assign WRITE = state == ISSUE;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      INADDRESS <= '0;
      IN        <= '0;
      rp        <= '0;
      wp        <= '0;
      cnt       <= '0;
      fv        <= '0;
      hv        <= 1'b0;
    end else begin
      state <= state_nx;
      if (pop) begin
        INADDRESS <= pop_fifo ? fa[rp] : ha;
        IN        <= pop_fifo ? fd[rp] : hd;
      end
      if (pop_fifo) rp <= nxt(rp);
      if (pop_fifo) fv[rp] <= 1'b0;
      if (push) wp <= nxt(wp);
      if (push) fv[wp] <= 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop_fifo);
      hv  <= load || (hv && !pop_hold);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fa[wp] <= alu_addr;
      fd[wp] <= alu_data;
    end
    if (load) begin
      ha <= mem_addr;
      hd <= mem_data;
      fg <= '1;
    end
    if (push) fg[wp] <= load;
  end

  a_no_overflow:  assert property (@(posedge CLK) disable iff (!RESET) !(push && full && !pop_fifo));
  a_no_underflow: assert property (@(posedge CLK) disable iff (!RESET) !(pop_fifo && cnt == '0));
  a_hold_clean:   assert property (@(posedge CLK) disable iff (!RESET) !(load && hv && !pop_hold));
  a_cnt_range:    assert property (@(posedge CLK) disable iff (!RESET) cnt <= CW'(FIFO_DEPTH));
endmodule
